hamming_decoder_pipe: RTL and testbench

Parametrised, pipelined Hamming syndrome decoder and corrector for the error-correction datapath. It accepts one codeword per cycle over a valid/ready handshake and computes the mod-2 syndrome against the standard positional parity-check matrix. It corrects single-bit errors, optionally detects double errors in SECDED mode, and emits the extracted data word with status flags. Saturating error counters are provided for link-quality monitoring.

---
 rtl/hamming_decoder_pipe.sv | 190 +++++++++++++++++++
 tb/tb_hamming_decoder_pipe.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/hamming_decoder_pipe.sv
`default_nettype none
// ============================================================================
// Module   : hamming_decoder_pipe
// Purpose  : Two-stage pipelined Hamming syndrome decoder / single-error
//            corrector with optional SECDED double-error detection and
//            saturating error counters for link-quality monitoring.
// Ports    : clk, rst_n                 - clock, async active-low reset
//            in_valid/in_ready/in_code  - codeword input handshake
//            out_valid/out_ready        - result output handshake
//            out_data, out_syndrome     - corrected data, raw syndrome
//            out_corrected              - single error was fixed
//            out_uncorrectable          - double error seen (SECDED only)
//            cnt_clr                    - synchronous clear of both counters
//            err_corr_cnt, err_unc_cnt  - saturating delivered-error counts
// Revision : 1.0 - initial release
// ============================================================================
module hamming_decoder_pipe #(
  parameter int R      = 3,
  parameter int SECDED = 0,
  parameter int CNT_W  = 16,
  localparam int N     = (1 << R) - 1,
  localparam int K     = N - R,
  localparam int CW    = N + SECDED
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [CW-1:0]    in_code,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [K-1:0]     out_data,
  output logic [R-1:0]     out_syndrome,
  output logic             out_corrected,
  output logic             out_uncorrectable,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] err_corr_cnt,
  output logic [CNT_W-1:0] err_unc_cnt
);

  // Codeword bit index (0-based) that carries data bit k: the k-th
  // non-power-of-two position, counted 1-indexed in ascending order.
  function automatic int data_pos(input int k);
    int cnt;
    cnt = 0;
    for (int p = 1; p <= N; p++) begin
      if ((p & (p - 1)) != 0) begin
        if (cnt == k) return p - 1;
        cnt++;
      end
    end
    return 0;
  endfunction

  // --------------------------------------------------------------------------
  // Stage-1 combinational: syndrome and overall parity of the incoming word
  // --------------------------------------------------------------------------
  logic [R-1:0] syn_c;
  logic         par_c;

  // Column i of H is simply the binary value i+1, so the syndrome is the XOR
  // of the positions of all set bits.
  always_comb begin
    syn_c = '0;
    for (int i = 0; i < N; i++) begin
      if (in_code[i]) syn_c = syn_c ^ R'(i + 1);
    end
  end

  generate
    if (SECDED != 0) begin : g_par
      assign par_c = ^in_code;
    end else begin : g_no_par
      assign par_c = 1'b0;
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Handshake / pipeline control
  // --------------------------------------------------------------------------
  logic         s1_valid;
  logic [N-1:0] s1_code;
  logic [R-1:0] s1_syn;
  logic         s1_par;
  logic         s2_load;

  assign s2_load  = !out_valid || out_ready;
  // Stage 1 can load whenever it is empty or drains into stage 2.
  assign in_ready = !(s1_valid && out_valid && !out_ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_code  <= '0;
      s1_syn   <= '0;
      s1_par   <= 1'b0;
    end else if (in_ready) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_code <= in_code[N-1:0];
        s1_syn  <= syn_c;
        s1_par  <= par_c;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Stage-2 combinational: correction decision, bit flip, data extraction
  // --------------------------------------------------------------------------
  logic         syn_nz;
  logic         flip_en;
  logic         corr_c;
  logic         unc_c;
  logic [N-1:0] fixed;
  logic [K-1:0] data_c;

  assign syn_nz = |s1_syn;

  always_comb begin
    flip_en = 1'b0;
    corr_c  = 1'b0;
    unc_c   = 1'b0;
    if (SECDED == 0) begin
      flip_en = syn_nz;
      corr_c  = syn_nz;
    end else begin
      case ({syn_nz, s1_par})
        2'b01: corr_c = 1'b1;                    // only the parity bit is bad
        2'b11: begin flip_en = 1'b1; corr_c = 1'b1; end
        2'b10: unc_c = 1'b1;                     // even error count, s != 0
        default: ;
      endcase
    end
  end

  always_comb begin
    fixed = s1_code;
    for (int i = 0; i < N; i++) begin
      if (flip_en && (s1_syn == R'(i + 1))) fixed[i] = ~s1_code[i];
    end
  end

  generate
    for (genvar k = 0; k < K; k++) begin : g_ext
      assign data_c[k] = fixed[data_pos(k)];
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Stage-2 registers drive the outputs directly; they hold while stalled.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid         <= 1'b0;
      out_data          <= '0;
      out_syndrome      <= '0;
      out_corrected     <= 1'b0;
      out_uncorrectable <= 1'b0;
    end else if (s2_load) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_data          <= data_c;
        out_syndrome      <= s1_syn;
        out_corrected     <= corr_c;
        out_uncorrectable <= unc_c;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Saturating error counters, counted on delivery; clear wins over increment
  // --------------------------------------------------------------------------
  logic out_fire;
  assign out_fire = out_valid && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_corr_cnt <= '0;
      err_unc_cnt  <= '0;
    end else if (cnt_clr) begin
      err_corr_cnt <= '0;
      err_unc_cnt  <= '0;
    end else if (out_fire) begin
      if (out_corrected && !(&err_corr_cnt))    err_corr_cnt <= err_corr_cnt + 1'b1;
      if (out_uncorrectable && !(&err_unc_cnt)) err_unc_cnt  <= err_unc_cnt + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_hamming_decoder_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_hamming_decoder_pipe
// Purpose  : Directed self-checking bench. Three decoder instances share one
//            clock and reset:
//              u_a : R=3, SECDED=0, CNT_W=16  (main datapath, backpressure)
//              u_b : R=3, SECDED=1, CNT_W=16  (SECDED cases)
//              u_c : R=3, SECDED=0, CNT_W=2   (same inputs as u_a; saturation)
// Revision : 1.1 - checking task and timeout watchdog
// ============================================================================
module tb_hamming_decoder_pipe;

    localparam int C_TIMEOUT_CYCLES = 2000;

    int checks = 0;
    int errors = 0;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic        a_in_valid, a_out_ready, a_cnt_clr;
    logic [6:0]  a_in_code;
    logic        a_in_ready, a_out_valid, a_out_corrected, a_out_unc;
    logic [3:0]  a_out_data;
    logic [2:0]  a_out_syn;
    logic [15:0] a_err_corr_cnt, a_err_unc_cnt;

    logic        c_in_ready, c_out_valid, c_out_corrected, c_out_unc;
    logic [3:0]  c_out_data;
    logic [2:0]  c_out_syn;
    logic [1:0]  c_err_corr_cnt, c_err_unc_cnt;

    logic        b_in_valid, b_out_ready, b_cnt_clr;
    logic [7:0]  b_in_code;
    logic        b_in_ready, b_out_valid, b_out_corrected, b_out_unc;
    logic [3:0]  b_out_data;
    logic [2:0]  b_out_syn;
    logic [15:0] b_err_corr_cnt, b_err_unc_cnt;

    bit done = 1'b0;

    hamming_decoder_pipe #(.R(3), .SECDED(0), .CNT_W(16)) u_a (
        .clk(clk), .rst_n(rst_n),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_code(a_in_code),
        .out_valid(a_out_valid), .out_ready(a_out_ready),
        .out_data(a_out_data), .out_syndrome(a_out_syn),
        .out_corrected(a_out_corrected), .out_uncorrectable(a_out_unc),
        .cnt_clr(a_cnt_clr), .err_corr_cnt(a_err_corr_cnt), .err_unc_cnt(a_err_unc_cnt)
    );

    hamming_decoder_pipe #(.R(3), .SECDED(1), .CNT_W(16)) u_b (
        .clk(clk), .rst_n(rst_n),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_code(b_in_code),
        .out_valid(b_out_valid), .out_ready(b_out_ready),
        .out_data(b_out_data), .out_syndrome(b_out_syn),
        .out_corrected(b_out_corrected), .out_uncorrectable(b_out_unc),
        .cnt_clr(b_cnt_clr), .err_corr_cnt(b_err_corr_cnt), .err_unc_cnt(b_err_unc_cnt)
    );

    hamming_decoder_pipe #(.R(3), .SECDED(0), .CNT_W(2)) u_c (
        .clk(clk), .rst_n(rst_n),
        .in_valid(a_in_valid), .in_ready(c_in_ready), .in_code(a_in_code),
        .out_valid(c_out_valid), .out_ready(a_out_ready),
        .out_data(c_out_data), .out_syndrome(c_out_syn),
        .out_corrected(c_out_corrected), .out_uncorrectable(c_out_unc),
        .cnt_clr(a_cnt_clr), .err_corr_cnt(c_err_corr_cnt), .err_unc_cnt(c_err_unc_cnt)
    );

    localparam logic [6:0] W0 = 7'b0000111;
    localparam logic [6:0] W1 = 7'b0011001;
    localparam logic [6:0] W2 = 7'b0101010;
    localparam logic [6:0] W3 = 7'b1001011;
    localparam logic [6:0] E5 = 7'b0010111;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        repeat (C_TIMEOUT_CYCLES) @(posedge clk);
        if (!done) begin
            errors++;
            $error("FAIL timeout: stimulus did not complete within %0d cycles", C_TIMEOUT_CYCLES);
            $display("CHECKS %0d ERRORS %0d", checks, errors);
            $finish;
        end
    end

    initial begin
        rst_n       = 1'b0;
        a_in_valid  = 1'b0; a_in_code = '0; a_out_ready = 1'b1; a_cnt_clr = 1'b0;
        b_in_valid  = 1'b0; b_in_code = '0; b_out_ready = 1'b1; b_cnt_clr = 1'b0;
        tick(); tick();

        check("rst_a_valid", a_out_valid, 1'b0);
        check("rst_a_data", a_out_data, 4'h0);
        check("rst_a_cnt", a_err_corr_cnt, 16'h0);
        check("rst_b_valid", b_out_valid, 1'b0);
        check("rst_b_unc", b_out_unc, 1'b0);
        check("rst_c_cnt", c_err_corr_cnt, 2'h0);

        rst_n = 1'b1;
        #1;
        check("post_rst_ready", a_in_ready, 1'b1);

        a_in_valid = 1'b1; a_in_code = W0;
        b_in_valid = 1'b1; b_in_code = 8'b10000111;
        tick();
        check("lat_not_early", a_out_valid, 1'b0);
        a_in_code = E5;
        b_in_code = 8'b00000111;
        tick();
        check("clean_valid", a_out_valid, 1'b1);
        check("clean_data", a_out_data, 4'b0001);
        check("clean_syn", a_out_syn, 3'b000);
        check("clean_corr", a_out_corrected, 1'b0);
        check("sd_clean_data", b_out_data, 4'b0001);
        check("sd_clean_corr", b_out_corrected, 1'b0);
        check("sd_clean_unc", b_out_unc, 1'b0);
        a_in_valid = 1'b0;
        b_in_code  = 8'b10000100;
        tick();
        check("e5_data", a_out_data, 4'b0001);
        check("e5_syn", a_out_syn, 3'b101);
        check("e5_corr", a_out_corrected, 1'b1);
        check("sd_par_syn", b_out_syn, 3'b000);
        check("sd_par_corr", b_out_corrected, 1'b1);
        check("sd_par_data", b_out_data, 4'b0001);
        check("sd_par_unc", b_out_unc, 1'b0);
        b_in_valid = 1'b0;
        tick();
        check("e5_drained", a_out_valid, 1'b0);
        check("a_cnt_1", a_err_corr_cnt, 16'd1);
        check("c_cnt_1", c_err_corr_cnt, 2'd1);
        check("sd_dbl_syn", b_out_syn, 3'b011);
        check("sd_dbl_unc", b_out_unc, 1'b1);
        check("sd_dbl_corr", b_out_corrected, 1'b0);
        check("sd_dbl_data", b_out_data, 4'b0001);
        tick();
        check("b_unc_cnt", b_err_unc_cnt, 16'd1);
        check("b_corr_cnt", b_err_corr_cnt, 16'd1);
        check("b_drained", b_out_valid, 1'b0);

        a_out_ready = 1'b0;
        a_in_valid  = 1'b1; a_in_code = W0;
        #1;
        check("bp_ready_empty", a_in_ready, 1'b1);
        tick();
        a_in_code = W1;
        tick();
        check("bp_valid", a_out_valid, 1'b1);
        check("bp_data0", a_out_data, 4'b0001);
        check("bp_full", a_in_ready, 1'b0);
        a_in_code = W2;
        tick();
        check("bp_hold1", a_out_data, 4'b0001);
        check("bp_hold_syn", a_out_syn, 3'b000);
        check("bp_full2", a_in_ready, 1'b0);
        tick();
        check("bp_hold2", a_out_data, 4'b0001);
        check("bp_hold_valid", a_out_valid, 1'b1);
        a_out_ready = 1'b1;
        #1;
        check("bp_ready_comb", a_in_ready, 1'b1);
        tick();
        check("bp_data1", a_out_data, 4'b0010);
        a_in_code = W3;
        tick();
        check("bp_data2", a_out_data, 4'b0100);
        a_in_valid = 1'b0;
        tick();
        check("bp_data3", a_out_data, 4'b1000);
        check("bp_valid3", a_out_valid, 1'b1);
        tick();
        check("bp_empty", a_out_valid, 1'b0);
        check("bp_cnt_same", a_err_corr_cnt, 16'd1);

        a_in_valid = 1'b1; a_in_code = E5;
        tick(); tick(); tick(); tick(); tick();
        a_in_valid = 1'b0;
        tick(); tick();
        check("sat_c", c_err_corr_cnt, 2'd3);
        check("cnt_a_6", a_err_corr_cnt, 16'd6);

        a_in_valid = 1'b1;
        tick();
        a_in_valid = 1'b0;
        tick();
        check("clr_word_corr", a_out_corrected, 1'b1);
        a_cnt_clr = 1'b1;
        tick();
        check("clr_a", a_err_corr_cnt, 16'd0);
        check("clr_c", c_err_corr_cnt, 2'd0);
        a_cnt_clr = 1'b0;
        tick();
        check("clr_a_hold", a_err_corr_cnt, 16'd0);
        check("clr_drained", a_out_valid, 1'b0);

        a_in_valid = 1'b1; a_in_code = W1;
        tick();
        a_in_code = W2;
        tick();
        check("mid_valid", a_out_valid, 1'b1);
        check("mid_data", a_out_data, 4'b0010);
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", a_out_valid, 1'b0);
        check("mid_rst_data", a_out_data, 4'h0);
        check("mid_rst_bcorr", b_err_corr_cnt, 16'd0);
        check("mid_rst_bunc", b_err_unc_cnt, 16'd0);
        tick(); tick();
        check("rst_ignores_in", a_out_valid, 1'b0);
        a_in_valid = 1'b0;
        rst_n = 1'b1;
        #1;
        check("rel_ready", a_in_ready, 1'b1);
        a_in_valid = 1'b1; a_in_code = E5;
        tick();
        check("rel_not_early", a_out_valid, 1'b0);
        a_in_valid = 1'b0;
        tick();
        check("rel_valid", a_out_valid, 1'b1);
        check("rel_data", a_out_data, 4'b0001);
        check("rel_syn", a_out_syn, 3'b101);
        check("rel_corr", a_out_corrected, 1'b1);

        done = 1'b1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
